// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants, coordinate type and window helper.
// Renderers import COORD_W / coord_t from here.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned COORD_MAX = 1 << COORD_W;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 2;

  localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input coord_t v, input int unsigned lo, input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_scanner_tick_divider.sv
// Clock-enable generator: one-clock tick every CLK_DIV system clocks.
// Also used for other clock-enable generation outside the scanner.
module tick_divider #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("tick_divider: CLK_DIV must be >= 1");
  end

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clock) begin
    if (reset || div_cnt == LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + CNT_W'(1);
  end

  assign tick = (div_cnt == LAST) && !reset;

endmodule

// File: rtl/vga_scanner.sv
// Raster timing generator: scan counters, sync decode and the registered
// pixel/sync output stage that drives the VGA connector.
module vga_scanner
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               display_on,
  output logic               pixel_tick,
  input  logic [2:0]         rgb_in,
  output logic [2:0]         vga_rgb,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_geometry
    $error("vga_scanner: H_TOTAL/V_TOTAL exceed the coordinate range");
  end

  localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
  localparam coord_t FRAME_ROW = coord_t'(V_VISIBLE - 1);

  tick_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_divider (
    .clock(clock),
    .reset(reset),
    .tick (pixel_tick)
  );

  logic line_end;
  assign line_end = (col == H_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pixel_tick) begin
      if (line_end) begin
        col <= '0;
        row <= (row == V_LAST) ? '0 : row + coord_t'(1);
      end else begin
        col <= col + coord_t'(1);
      end
    end
  end

  assign display_on = (32'(col) < H_VISIBLE) && (32'(row) < V_VISIBLE);

  // Pixel and syncs are sampled together so they leave one pixel period late, unskewed.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_rgb <= '0;
      hsync   <= ~SYNC_ACTIVE;
      vsync   <= ~SYNC_ACTIVE;
    end else if (pixel_tick) begin
      vga_rgb <= display_on ? rgb_in : '0;
      hsync   <= in_window(col, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync   <= in_window(row, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  assign frame_tick = pixel_tick && line_end && (row == FRAME_ROW);

endmodule

// File: tb/tb_vga_scanner.sv
// Self-checking bench for vga_scanner on a reduced raster geometry, checked
// against a closed-form model of the scan derived from elapsed clock count.
module tb_vga_scanner;
  import vga_timing_pkg::*;

  localparam int HV = 40, HF = 4, HS = 6, HB = 5;
  localparam int VV = 30, VF = 3, VS = 2, VB = 4;
  localparam int CD = 2;
  localparam logic SA = 1'b0;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int HSS = HV + HF, HSE = HSS + HS;
  localparam int VSS = VV + VF, VSE = VSS + VS;
  localparam int FRAME = HT * VT * CD;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [COORD_W-1:0] col, row;
  logic display_on, pixel_tick, frame_tick, hsync, vsync;
  logic [2:0] rgb_in, vga_rgb;

  int mode = 0;
  int unsigned seed = 0;
  int t = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  // Clocks elapsed since reset was released.
  always @(posedge clock) t <= reset ? 0 : t + 1;

  function automatic logic [2:0] pattern(input int md, input int r, input int c);
    int h;
    case (md)
      0:       return 3'b111;
      1:       return c[2:0];
      default: begin h = r * 13 + c * 7 + int'(seed % 8); return h[2:0]; end
    endcase
  endfunction

  assign rgb_in = pattern(mode, int'(row), int'(col));

  function automatic int pix(input int tt);   return tt / CD; endfunction
  function automatic int m_col(input int tt); return pix(tt) % HT; endfunction
  function automatic int m_row(input int tt); return (pix(tt) / HT) % VT; endfunction
  function automatic logic m_tick(input int tt); return (tt % CD) == CD - 1; endfunction
  function automatic logic m_disp(input int tt); return m_col(tt) < HV && m_row(tt) < VV; endfunction
  function automatic logic m_frame(input int tt);
    return m_tick(tt) && m_col(tt) == HT - 1 && m_row(tt) == VV - 1;
  endfunction
  function automatic logic [2:0] m_rgb(input int tt);
    int q, c, r;
    if (pix(tt) == 0) return 3'b000;
    q = pix(tt) - 1; c = q % HT; r = (q / HT) % VT;
    return (c < HV && r < VV) ? pattern(mode, r, c) : 3'b000;
  endfunction
  function automatic logic m_hsync(input int tt);
    int c;
    if (pix(tt) == 0) return ~SA;
    c = (pix(tt) - 1) % HT;
    return (c >= HSS && c < HSE) ? SA : ~SA;
  endfunction
  function automatic logic m_vsync(input int tt);
    int r;
    if (pix(tt) == 0) return ~SA;
    r = ((pix(tt) - 1) / HT) % VT;
    return (r >= VSS && r < VSE) ? SA : ~SA;
  endfunction

  vga_scanner #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(CD), .SYNC_ACTIVE(SA)
  ) dut (
    .clock(clock), .reset(reset), .col(col), .row(row),
    .display_on(display_on), .pixel_tick(pixel_tick), .rgb_in(rgb_in),
    .vga_rgb(vga_rgb), .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick)
  );

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (col !== '0) begin n_fail++; $display("FAIL reset.col got=%0d exp=0", col); end
    n_checks++; if (row !== '0) begin n_fail++; $display("FAIL reset.row got=%0d exp=0", row); end
    n_checks++; if (pixel_tick !== 1'b0) begin n_fail++; $display("FAIL reset.pixel_tick got=%b exp=0", pixel_tick); end
    n_checks++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset.frame_tick got=%b exp=0", frame_tick); end
    n_checks++; if (vga_rgb !== 3'b000) begin n_fail++; $display("FAIL reset.vga_rgb got=%b exp=000", vga_rgb); end
    n_checks++; if (hsync !== ~SA) begin n_fail++; $display("FAIL reset.hsync got=%b exp=%b", hsync, ~SA); end
    n_checks++; if (vsync !== ~SA) begin n_fail++; $display("FAIL reset.vsync got=%b exp=%b", vsync, ~SA); end
    n_checks++; if (display_on !== 1'b1) begin n_fail++; $display("FAIL reset.display_on got=%b exp=1", display_on); end
  endtask

  task automatic test_startup();
    int first_tick = -1;
    mode = 0;
    do_reset(2);
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (first_tick < 0 && pixel_tick === 1'b1) first_tick = t;
      n_checks++; if (pixel_tick !== m_tick(t)) begin n_fail++; $display("FAIL startup.pixel_tick t=%0d got=%b exp=%b", t, pixel_tick, m_tick(t)); end
      n_checks++; if (col !== 10'(m_col(t))) begin n_fail++; $display("FAIL startup.col t=%0d got=%0d exp=%0d", t, col, m_col(t)); end
      n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL startup.sync t=%0d got=%b%b exp=11", t, hsync, vsync); end
    end
    n_checks++; if (first_tick !== 1) begin n_fail++; $display("FAIL startup.first_tick got=%0d exp=1", first_tick); end
  endtask

  task automatic test_pixel_stream(input int md, input int cycles);
    mode = md;
    seed = $urandom;
    do_reset(1 + int'($urandom_range(3)));
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      n_checks++; if (col !== 10'(m_col(t))) begin n_fail++; $display("FAIL stream.col m=%0d t=%0d got=%0d exp=%0d", md, t, col, m_col(t)); end
      n_checks++; if (row !== 10'(m_row(t))) begin n_fail++; $display("FAIL stream.row m=%0d t=%0d got=%0d exp=%0d", md, t, row, m_row(t)); end
      n_checks++; if (display_on !== m_disp(t)) begin n_fail++; $display("FAIL stream.display_on m=%0d t=%0d got=%b exp=%b", md, t, display_on, m_disp(t)); end
      n_checks++; if (pixel_tick !== m_tick(t)) begin n_fail++; $display("FAIL stream.pixel_tick m=%0d t=%0d got=%b exp=%b", md, t, pixel_tick, m_tick(t)); end
      n_checks++; if (frame_tick !== m_frame(t)) begin n_fail++; $display("FAIL stream.frame_tick m=%0d t=%0d got=%b exp=%b", md, t, frame_tick, m_frame(t)); end
      n_checks++; if (vga_rgb !== m_rgb(t)) begin n_fail++; $display("FAIL stream.vga_rgb m=%0d t=%0d got=%b exp=%b", md, t, vga_rgb, m_rgb(t)); end
      n_checks++; if (hsync !== m_hsync(t)) begin n_fail++; $display("FAIL stream.hsync m=%0d t=%0d got=%b exp=%b", md, t, hsync, m_hsync(t)); end
      n_checks++; if (vsync !== m_vsync(t)) begin n_fail++; $display("FAIL stream.vsync m=%0d t=%0d got=%b exp=%b", md, t, vsync, m_vsync(t)); end
    end
  endtask

  task automatic test_line();
    int t_fall = -1, t_rise = -1;
    bit wrap_seen = 1'b0;
    mode = 0;
    do_reset(2);
    for (int i = 0; i < 3 * HT * CD; i++) begin
      @(negedge clock);
      if (t_fall < 0 && hsync === SA) t_fall = t;
      else if (t_fall >= 0 && t_rise < 0 && hsync !== SA) t_rise = t;
      if (t == HT * CD - 1) begin
        n_checks++; if (col !== 10'(HT - 1) || row !== '0 || pixel_tick !== 1'b1) begin n_fail++; $display("FAIL line.before_wrap got=%0d,%0d,%b exp=%0d,0,1", col, row, pixel_tick, HT - 1); end
      end
      if (t == HT * CD) begin
        wrap_seen = 1'b1;
        n_checks++; if (col !== '0 || row !== 10'(1)) begin n_fail++; $display("FAIL line.after_wrap got=%0d,%0d exp=0,1", col, row); end
      end
    end
    n_checks++; if (!wrap_seen) begin n_fail++; $display("FAIL line.wrap_reached got=0 exp=1"); end
    n_checks++; if (t_fall != (HSS + 1) * CD) begin n_fail++; $display("FAIL line.hsync_start got=%0d exp=%0d", t_fall, (HSS + 1) * CD); end
    n_checks++; if (t_rise - t_fall != HS * CD) begin n_fail++; $display("FAIL line.hsync_width got=%0d exp=%0d", t_rise - t_fall, HS * CD); end
  endtask

  task automatic test_frame();
    int ft[$];
    int run = 0, max_run = 0, v_fall = -1, v_rise = -1, ft0 = -1, ft1 = -1;
    logic prev_ft = 1'b0;
    mode = 0;
    do_reset(2);
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      @(negedge clock);
      if (frame_tick === 1'b1 && prev_ft !== 1'b1) ft.push_back(t);
      run = (frame_tick === 1'b1) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      prev_ft = frame_tick;
      if (v_fall < 0 && vsync === SA) v_fall = t;
      else if (v_fall >= 0 && v_rise < 0 && vsync !== SA) v_rise = t;
      if (t == FRAME - 1) begin
        n_checks++; if (row !== 10'(VT - 1) || col !== 10'(HT - 1)) begin n_fail++; $display("FAIL frame.before_wrap got=%0d,%0d exp=%0d,%0d", col, row, HT - 1, VT - 1); end
      end
      if (t == FRAME) begin
        n_checks++; if (row !== '0 || col !== '0) begin n_fail++; $display("FAIL frame.after_wrap got=%0d,%0d exp=0,0", col, row); end
      end
    end
    if (ft.size() > 0) ft0 = ft[0];
    if (ft.size() > 1) ft1 = ft[1];
    n_checks++; if (ft.size() != 2) begin n_fail++; $display("FAIL frame.tick_count got=%0d exp=2", ft.size()); end
    n_checks++; if (ft0 != VV * HT * CD - 1) begin n_fail++; $display("FAIL frame.tick_first got=%0d exp=%0d", ft0, VV * HT * CD - 1); end
    n_checks++; if (ft1 - ft0 != FRAME) begin n_fail++; $display("FAIL frame.tick_period got=%0d exp=%0d", ft1 - ft0, FRAME); end
    n_checks++; if (max_run != 1) begin n_fail++; $display("FAIL frame.tick_width got=%0d exp=1", max_run); end
    n_checks++; if (v_fall != (VSS * HT + 1) * CD) begin n_fail++; $display("FAIL frame.vsync_start got=%0d exp=%0d", v_fall, (VSS * HT + 1) * CD); end
    n_checks++; if (v_rise - v_fall != VS * HT * CD) begin n_fail++; $display("FAIL frame.vsync_width got=%0d exp=%0d", v_rise - v_fall, VS * HT * CD); end
  endtask

  task automatic test_mid_reset();
    int tc[3], tr[3];
    bit reached;
    tc[0] = 30;      tr[0] = 20;
    tc[1] = HSS + 1 + int'($urandom_range(HS - 2)); tr[1] = int'($urandom_range(VV - 1));
    tc[2] = HSS + 2; tr[2] = VSS;
    mode = 1;
    for (int k = 0; k < 3; k++) begin
      do_reset(2);
      reached = 1'b0;
      for (int i = 0; i < FRAME && !reached; i++) begin
        @(negedge clock);
        if (m_col(t) == tc[k] && m_row(t) == tr[k]) reached = 1'b1;
      end
      n_checks++; if (!reached || col !== 10'(tc[k]) || row !== 10'(tr[k])) begin n_fail++; $display("FAIL midreset.reach%0d got=%0d,%0d exp=%0d,%0d", k, col, row, tc[k], tr[k]); end
      reset = 1'b1;
      @(negedge clock);
      n_checks++; if (col !== '0 || row !== '0) begin n_fail++; $display("FAIL midreset.counters%0d got=%0d,%0d exp=0,0", k, col, row); end
      n_checks++; if (vga_rgb !== 3'b000) begin n_fail++; $display("FAIL midreset.vga_rgb%0d got=%b exp=000", k, vga_rgb); end
      n_checks++; if (hsync !== ~SA || vsync !== ~SA) begin n_fail++; $display("FAIL midreset.sync%0d got=%b%b exp=%b%b", k, hsync, vsync, ~SA, ~SA); end
      n_checks++; if (pixel_tick !== 1'b0 || frame_tick !== 1'b0) begin n_fail++; $display("FAIL midreset.ticks%0d got=%b%b exp=00", k, pixel_tick, frame_tick); end
      reset = 1'b0;
      for (int i = 0; i < 2 * HT * CD + 6; i++) begin
        @(negedge clock);
        n_checks++; if (col !== 10'(m_col(t)) || row !== 10'(m_row(t))) begin n_fail++; $display("FAIL midreset.resume_pos%0d t=%0d got=%0d,%0d exp=%0d,%0d", k, t, col, row, m_col(t), m_row(t)); end
        n_checks++; if (vga_rgb !== m_rgb(t)) begin n_fail++; $display("FAIL midreset.resume_rgb%0d t=%0d got=%b exp=%b", k, t, vga_rgb, m_rgb(t)); end
        n_checks++; if (hsync !== m_hsync(t)) begin n_fail++; $display("FAIL midreset.resume_hsync%0d t=%0d got=%b exp=%b", k, t, hsync, m_hsync(t)); end
      end
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog timeout at t=%0d", t);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_frame();
    test_pixel_stream(0, FRAME + 10);
    test_pixel_stream(1, FRAME + 10);
    test_pixel_stream(2, FRAME / 2 + int'($urandom_range(FRAME / 2)));
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
